// File: rtl/cl_crc_pkg.sv
// cl_crc_pkg: shared state type, standard CRC parameter sets and the bit-level
// helpers used by the streaming CRC engine and its byte lanes.
package cl_crc_pkg;

   // Widest CRC register the helpers handle; narrower CRCs sit in the low bits.
   localparam int CRC_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } cl_crc_state_e;

   // CRC-32 (IEEE 802.3 FCS), reflected in and out.
   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'h2144DF1C;

   // CRC-16-CCITT (false variant), not reflected.
   localparam logic [15:0] CRC16_CCITT_POLY   = 16'h1021;
   localparam logic [15:0] CRC16_CCITT_INIT   = 16'hFFFF;
   localparam logic [15:0] CRC16_CCITT_XOROUT = 16'h0000;

   // CRC-8 (SMBus PEC), not reflected.
   localparam logic [7:0] CRC8_POLY   = 8'h07;
   localparam logic [7:0] CRC8_INIT   = 8'h00;
   localparam logic [7:0] CRC8_XOROUT = 8'h00;

   // Reverse the low 'width' bits of value; bits above 'width' come back as zero.
   function automatic logic [CRC_MAX_W-1:0] reflect(input logic [CRC_MAX_W-1:0] value,
                                                    input int width);
      logic [CRC_MAX_W-1:0] result;
      result = '0;
      for (int i = 0; i < CRC_MAX_W; i++) begin
         if (i < width) begin
            result[6'(i)] = value[6'(width - 1 - i)];
         end
      end
      return result;
   endfunction

   // Shift one byte MSB first into a 'width'-bit CRC register (non-reflected form).
   // Callers wanting LSB-first processing reflect the byte before calling.
   function automatic logic [CRC_MAX_W-1:0] crc_byte_update(input logic [CRC_MAX_W-1:0] crc,
                                                            input logic [7:0] data,
                                                            input logic [CRC_MAX_W-1:0] poly,
                                                            input int width);
      logic [CRC_MAX_W-1:0] state;
      logic [CRC_MAX_W-1:0] mask;
      logic                 feedback;
      mask  = (width >= CRC_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
      state = crc & mask;
      for (int i = 7; i >= 0; i--) begin
         feedback = state[6'(width - 1)] ^ data[3'(i)];
         state    = (state << 1) & mask;
         if (feedback) begin
            state = state ^ (poly & mask);
         end
      end
      return state;
   endfunction

endpackage

// File: rtl/cl_crc_stream_byte_lane.sv
// cl_crc_byte_lane: combinational single-byte CRC update. A cleared enable
// passes the incoming register through untouched, so a chain of lanes
// naturally skips bytes whose keep bit is low.
module cl_crc_byte_lane
   import cl_crc_pkg::*;
#(
   parameter int               CRC_W      = 32,
   parameter logic [CRC_W-1:0] POLY       = CRC_W'(CRC32_POLY),
   parameter bit               REFLECT_IN = 1'b1
) (
   input  logic [CRC_W-1:0] crc_in,
   input  logic [7:0]       data,
   input  logic             enable,
   output logic [CRC_W-1:0] crc_out
);

   logic [7:0]       data_ordered;
   logic [CRC_W-1:0] crc_updated;

   // Reflecting the byte turns LSB-first wire order into the MSB-first shift the helper performs.
   always_comb begin
      data_ordered = REFLECT_IN ? 8'(reflect(CRC_MAX_W'(data), 8)) : data;
      crc_updated  = CRC_W'(crc_byte_update(CRC_MAX_W'(crc_in), data_ordered,
                                            CRC_MAX_W'(POLY), CRC_W));
      crc_out      = enable ? crc_updated : crc_in;
   end

endmodule

// File: rtl/cl_crc_stream.sv
// cl_crc_stream: packet-framed streaming CRC engine with byte enables.
// Each accepted beat folds its kept bytes (byte 0 first) into the CRC in one
// cycle; the packet result, byte count and keep-error flag are presented on a
// valid/ready result port the cycle after the last beat.
// Optional build macro CL_CRC_RESIDUE_CHECK_EN adds a RESIDUE parameter and
// drives m_match with a comparison of the final CRC against it; without the
// macro m_match is tied low.
module cl_crc_stream
   import cl_crc_pkg::*;
#(
   parameter int               CRC_W       = 32,
   parameter logic [CRC_W-1:0] POLY        = CRC_W'(CRC32_POLY),
   parameter logic [CRC_W-1:0] INIT        = '1,
   parameter logic [CRC_W-1:0] XOR_OUT     = '1,
   parameter bit               REFLECT_IN  = 1'b1,
   parameter bit               REFLECT_OUT = 1'b1,
`ifdef CL_CRC_RESIDUE_CHECK_EN
   parameter logic [CRC_W-1:0] RESIDUE     = CRC_W'(CRC32_RESIDUE),
`endif
   parameter int               DATA_W      = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_W-1:0]     s_data,
   input  logic [DATA_W/8-1:0]   s_keep,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CRC_W-1:0]      m_crc,
   output logic [15:0]           m_len,
   output logic                  m_err,
   output logic                  m_match,
   output logic                  busy
);

   localparam int BYTES = DATA_W / 8;

   cl_crc_state_e    state_q;
   logic [CRC_W-1:0] crc_q;
   logic [15:0]      len_q;
   logic             err_q;

   logic [CRC_W-1:0] crc_start;
   logic [15:0]      len_start;
   logic             err_start;
   logic [CRC_W-1:0] lane_crc [BYTES+1];
   logic [CRC_W-1:0] crc_next;
   logic [CRC_W-1:0] crc_final;
   logic [16:0]      len_sum;
   logic [15:0]      len_next;
   logic [BYTES-1:0] keep_inc;
   logic             keep_bad;
   logic             err_next;

   assign s_ready = (state_q != HOLD);
   assign busy    = (state_q != IDLE);

   // The first beat of a packet always starts from INIT and a clean count,
   // whatever the accumulators happen to hold.
   always_comb begin
      crc_start = crc_q;
      len_start = len_q;
      err_start = err_q;
      if (state_q == IDLE) begin
         crc_start = INIT;
         len_start = '0;
         err_start = 1'b0;
      end
   end

   assign lane_crc[0] = crc_start;

   for (genvar i = 0; i < BYTES; i++) begin : g_lane
      cl_crc_byte_lane #(
         .CRC_W      (CRC_W),
         .POLY       (POLY),
         .REFLECT_IN (REFLECT_IN)
      ) u_lane (
         .crc_in  (lane_crc[i]),
         .data    (s_data[8*i +: 8]),
         .enable  (s_keep[i]),
         .crc_out (lane_crc[i+1])
      );
   end

   assign crc_next = lane_crc[BYTES];

   // Result formatting, byte counting with saturation, and keep legality.
   // A legal last-beat keep is a run of ones from bit 0, which is exactly the
   // set of values where keep & (keep + 1) is zero (including zero and all ones).
   always_comb begin
      crc_final = (REFLECT_OUT ? CRC_W'(reflect(CRC_MAX_W'(crc_next), CRC_W)) : crc_next)
                  ^ XOR_OUT;
      len_sum   = {1'b0, len_start} + 17'($countones(s_keep));
      len_next  = len_sum[16] ? 16'hFFFF : len_sum[15:0];
      keep_inc  = s_keep + BYTES'(1);
      keep_bad  = s_last ? ((s_keep & keep_inc) != '0) : (s_keep != '1);
      err_next  = err_start | keep_bad;
   end

   // Packet FSM: accumulate beats, then hold the registered result until it is taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         crc_q   <= INIT;
         len_q   <= '0;
         err_q   <= 1'b0;
         m_valid <= 1'b0;
         m_crc   <= '0;
         m_len   <= '0;
         m_err   <= 1'b0;
`ifdef CL_CRC_RESIDUE_CHECK_EN
         m_match <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, ACC: begin
               if (s_valid) begin
                  crc_q <= crc_next;
                  len_q <= len_next;
                  err_q <= err_next;
                  if (s_last) begin
                     state_q <= HOLD;
                     m_valid <= 1'b1;
                     m_crc   <= crc_final;
                     m_len   <= len_next;
                     m_err   <= err_next;
`ifdef CL_CRC_RESIDUE_CHECK_EN
                     m_match <= (crc_final == RESIDUE);
`endif
                  end else begin
                     state_q <= ACC;
                  end
               end
            end
            HOLD: begin
               if (m_ready) begin
                  state_q <= IDLE;
                  m_valid <= 1'b0;
                  crc_q   <= INIT;
                  len_q   <= '0;
                  err_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifndef CL_CRC_RESIDUE_CHECK_EN
   assign m_match = 1'b0;
`endif

endmodule

// File: tb/tb_cl_crc_stream.sv
// tb_cl_crc_stream: randomized self-checking bench for cl_crc_stream at its
// default CRC-32 / 64-bit configuration. Expected results come from a plain
// reflected CRC-32 reference and the keep rules applied to each packet.
`timescale 1ns/1ps
module tb_cl_crc_stream;

`ifdef CL_CRC_RESIDUE_CHECK_EN
   localparam bit RESIDUE_EN = 1'b1;
`else
   localparam bit RESIDUE_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] crc;
      logic [15:0] len;
      logic        err;
      logic        match;
   } exp_t;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [63:0] s_data  = '0;
   logic [7:0]  s_keep  = '0;
   logic        s_last  = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_crc;
   logic [15:0] m_len;
   logic        m_err;
   logic        m_match;
   logic        busy;

   int   n_checks   = 0;
   int   n_errors   = 0;
   int   ready_mode = 1;
   int   gap_max    = 0;
   exp_t exp_q[$];

   logic [63:0] beat_data[$];
   logic [7:0]  beat_keep[$];
   bit          beat_last[$];

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   cl_crc_stream dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_keep  (s_keep),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_crc   (m_crc),
      .m_len   (m_len),
      .m_err   (m_err),
      .m_match (m_match),
      .busy    (busy)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic report_fail(input string name, input int waited);
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: gave up after %0d cycles, expected completion", name, waited);
   endtask

   // Reference CRC-32: reflected shift-right form with the reversed polynomial.
   function automatic logic [31:0] model_crc32(input logic [7:0] b[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (b[i]) begin
         c = c ^ {24'h0, b[i]};
         for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   function automatic void push_ascii_123456789(ref logic [7:0] q[$]);
      for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
   endfunction

   // Split a byte stream into 8-byte beats with keep contiguous from bit 0.
   task automatic make_packet(input logic [7:0] b[$]);
      int n;
      int nb;
      beat_data.delete();
      beat_keep.delete();
      beat_last.delete();
      n  = b.size();
      nb = (n == 0) ? 1 : (n + 7) / 8;
      for (int k = 0; k < nb; k++) begin
         logic [63:0] d;
         logic [7:0]  kp;
         d  = '0;
         kp = '0;
         for (int i = 0; i < 8; i++) begin
            if (k * 8 + i < n) begin
               d[8*i +: 8] = b[k*8 + i];
               kp[i]       = 1'b1;
            end
         end
         beat_data.push_back(d);
         beat_keep.push_back(kp);
         beat_last.push_back(k == nb - 1);
      end
   endtask

   // Present one beat from a negedge and return on the negedge after it is taken.
   task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input bit l);
      int waited;
      waited  = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      while (!s_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!s_ready) report_fail("s_ready_wait", waited);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Compute the expected result from the queued beats, then drive them.
   task automatic applyStimulus();
      logic [7:0] bytes_q[$];
      bit         err;
      bit         legal;
      exp_t       e;
      err = 1'b0;
      for (int b = 0; b < beat_keep.size(); b++) begin
         if (!beat_last[b]) begin
            legal = (beat_keep[b] == 8'hFF);
         end else begin
            legal = 1'b0;
            for (int n = 0; n <= 8; n++) begin
               if (beat_keep[b] == 8'((16'd1 << n) - 16'd1)) legal = 1'b1;
            end
         end
         if (!legal) err = 1'b1;
         for (int i = 0; i < 8; i++) begin
            if (beat_keep[b][i]) bytes_q.push_back(beat_data[b][8*i +: 8]);
         end
      end
      e.crc   = model_crc32(bytes_q);
      e.len   = (bytes_q.size() > 65535) ? 16'hFFFF : 16'(bytes_q.size());
      e.err   = err;
      e.match = RESIDUE_EN && (e.crc == 32'h2144DF1C);
      for (int b = 0; b < beat_keep.size(); b++) begin
         repeat ($urandom_range(0, gap_max)) @(negedge clk);
         if (beat_last[b]) exp_q.push_back(e);
         drive_beat(beat_data[b], beat_keep[b], beat_last[b]);
      end
   endtask

   task automatic wait_result(input string name);
      int w;
      w = 0;
      #2;
      while (!m_valid && w < 200) begin
         @(negedge clk);
         #2;
         w++;
      end
      if (!m_valid) report_fail(name, w);
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) report_fail("drain", w);
   endtask

   // Compare process: every negedge out of reset, hold the result port against
   // the oldest outstanding packet, then choose m_ready for the coming edge.
   initial begin : compare
      int idle_cycles;
      bit after_hs;
      idle_cycles = 0;
      after_hs    = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            after_hs    = 1'b0;
            idle_cycles = 0;
            m_ready     = 1'b0;
         end else begin
            checkOutput("s_ready_vs_m_valid", 64'(s_ready), 64'(!m_valid));
            if (after_hs) begin
               checkOutput("m_valid_after_handshake", 64'(m_valid), 64'd0);
               checkOutput("s_ready_after_handshake", 64'(s_ready), 64'd1);
               after_hs = 1'b0;
            end
            if (m_valid) begin
               idle_cycles = 0;
               if (exp_q.size() == 0) begin
                  checkOutput("m_valid_spurious", 64'(m_valid), 64'd0);
               end else begin
                  checkOutput("m_crc", 64'(m_crc), 64'(exp_q[0].crc));
                  checkOutput("m_len", 64'(m_len), 64'(exp_q[0].len));
                  checkOutput("m_err", 64'(m_err), 64'(exp_q[0].err));
                  checkOutput("m_match", 64'(m_match), 64'(exp_q[0].match));
               end
            end else if (exp_q.size() != 0) begin
               idle_cycles++;
               if (idle_cycles > 500) begin
                  report_fail("result_timeout", idle_cycles);
                  void'(exp_q.pop_front());
                  idle_cycles = 0;
               end
            end
            case (ready_mode)
               0:       m_ready = ($urandom_range(0, 2) != 0);
               2:       m_ready = 1'b0;
               default: m_ready = 1'b1;
            endcase
            if (m_valid && m_ready && exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               after_hs = 1'b1;
            end
         end
      end
   end

   // Hard stop in case the stimulus itself wedges.
   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
      n_errors++;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized packets.
   initial begin : main
      logic [7:0] pkt[$];
      logic [7:0] empty_q[$];

      // Pin the reference model to known CRC-32 values.
      pkt.delete();
      push_ascii_123456789(pkt);
      checkOutput("model_check_123456789", 64'(model_crc32(pkt)), 64'h00000000CBF43926);
      checkOutput("model_empty", 64'(model_crc32(empty_q)), 64'h0);
      pkt.push_back(8'h26); pkt.push_back(8'h39); pkt.push_back(8'hF4); pkt.push_back(8'hCB);
      checkOutput("model_residue", 64'(model_crc32(pkt)), 64'h000000002144DF1C);

      // Reset and idle outputs.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #2;
      checkOutput("reset_m_valid", 64'(m_valid), 64'd0);
      checkOutput("reset_m_crc", 64'(m_crc), 64'd0);
      checkOutput("reset_m_len", 64'(m_len), 64'd0);
      checkOutput("reset_m_err", 64'(m_err), 64'd0);
      checkOutput("reset_m_match", 64'(m_match), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_s_ready", 64'(s_ready), 64'd1);
      @(negedge clk);

      // "123456789" over two beats with the result held back for five cycles.
      ready_mode = 2;
      gap_max    = 0;
      pkt.delete();
      push_ascii_123456789(pkt);
      make_packet(pkt);
      applyStimulus();
      wait_result("hold_result");
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_m_valid", 64'(m_valid), 64'd1);
         checkOutput("hold_m_crc", 64'(m_crc), 64'h00000000CBF43926);
         checkOutput("hold_m_len", 64'(m_len), 64'd9);
         checkOutput("hold_m_err", 64'(m_err), 64'd0);
         checkOutput("hold_s_ready", 64'(s_ready), 64'd0);
         checkOutput("hold_busy", 64'(busy), 64'd1);
         @(negedge clk);
         #2;
      end
      ready_mode = 1;
      @(negedge clk);
      #2;
      @(negedge clk);
      #2;
      checkOutput("released_m_valid", 64'(m_valid), 64'd0);
      checkOutput("released_s_ready", 64'(s_ready), 64'd1);
      wait_drain();

      // Zero-byte packet, then back-to-back packets with no source idles.
      make_packet(empty_q);
      applyStimulus();
      wait_result("zero_result");
      checkOutput("zero_m_crc", 64'(m_crc), 64'd0);
      checkOutput("zero_m_len", 64'(m_len), 64'd0);
      for (int p = 0; p < 6; p++) begin
         pkt.delete();
         if (p == 1) push_ascii_123456789(pkt);
         else if (p != 4) repeat ($urandom_range(1, 20)) pkt.push_back(8'($urandom));
         make_packet(pkt);
         applyStimulus();
      end
      wait_drain();

      // Non-contiguous last-beat keep flags an error; the next packet is clean.
      beat_data.delete(); beat_keep.delete(); beat_last.delete();
      beat_data.push_back({$urandom, $urandom});
      beat_keep.push_back(8'h05);
      beat_last.push_back(1'b1);
      applyStimulus();
      wait_result("keep05_result");
      checkOutput("keep05_m_err", 64'(m_err), 64'd1);
      checkOutput("keep05_m_len", 64'(m_len), 64'd2);
      pkt.delete();
      push_ascii_123456789(pkt);
      make_packet(pkt);
      applyStimulus();
      wait_result("after_err_result");
      checkOutput("after_err_m_err", 64'(m_err), 64'd0);
      wait_drain();

      // Good FCS appended gives the residue; a flipped data bit does not.
      pkt.delete();
      push_ascii_123456789(pkt);
      pkt.push_back(8'h26); pkt.push_back(8'h39); pkt.push_back(8'hF4); pkt.push_back(8'hCB);
      make_packet(pkt);
      applyStimulus();
      wait_result("residue_result");
      checkOutput("residue_m_crc", 64'(m_crc), 64'h000000002144DF1C);
      checkOutput("residue_m_match", 64'(m_match), 64'(RESIDUE_EN));
      pkt[3] = pkt[3] ^ 8'h01;
      make_packet(pkt);
      applyStimulus();
      wait_result("residue_bad_result");
      checkOutput("residue_bad_m_match", 64'(m_match), 64'd0);
      wait_drain();

      // Reset after the first beat discards the packet; a fresh one is unaffected.
      drive_beat(64'h3837363534333231, 8'hFF, 1'b0);
      checkOutput("midpkt_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      checkOutput("midpkt_reset_m_valid", 64'(m_valid), 64'd0);
      checkOutput("midpkt_reset_busy", 64'(busy), 64'd0);
      checkOutput("midpkt_reset_s_ready", 64'(s_ready), 64'd1);
      repeat (3) @(negedge clk);
      pkt.delete();
      push_ascii_123456789(pkt);
      make_packet(pkt);
      applyStimulus();
      wait_result("post_reset_result");
      checkOutput("post_reset_m_crc", 64'(m_crc), 64'h00000000CBF43926);
      wait_drain();

      // Long packet: byte count saturates instead of wrapping.
      pkt.delete();
      repeat (65600) pkt.push_back(8'($urandom));
      make_packet(pkt);
      applyStimulus();
      wait_result("saturate_result");
      checkOutput("saturate_m_len", 64'(m_len), 64'hFFFF);
      wait_drain();

      // Randomized packets with source gaps, result backpressure and bad keeps.
      ready_mode = 0;
      gap_max    = 2;
      for (int p = 0; p < 60; p++) begin
         pkt.delete();
         repeat ($urandom_range(0, 40)) pkt.push_back(8'($urandom));
         make_packet(pkt);
         if ($urandom_range(0, 5) == 0) begin
            int idx;
            idx = int'($urandom_range(0, beat_keep.size() - 1));
            beat_keep[idx] = 8'($urandom);
         end
         applyStimulus();
      end
      wait_drain();
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
